// File: rtl/input_tile_fetcher_if.sv
// Tile request bus between the input-transform data controller (master)
// and the input tile fetcher (slave).
//
// Signals:
//   fmap_length_i / fmap_width_i   feature-map extent (rows / columns)
//   input_addr_{x,y}_i_{1,2}       origins of the two requested tiles
//   input_request_i                fetch request level from the controller
//   input_data_o_{1,2}             6x6 tiles of signed DATA_W-bit pixels, [row][col]
//   input_valid_o                  one-cycle pulse: both tiles are complete
interface input_tile_fetcher_if #(
    parameter int DATA_W = 16
);
    logic [15:0]                          fmap_length_i;
    logic [15:0]                          fmap_width_i;
    logic [15:0]                          input_addr_x_i_1;
    logic [15:0]                          input_addr_y_i_1;
    logic [15:0]                          input_addr_x_i_2;
    logic [15:0]                          input_addr_y_i_2;
    logic                                 input_request_i;
    logic signed [5:0][5:0][DATA_W-1:0]   input_data_o_1;
    logic signed [5:0][5:0][DATA_W-1:0]   input_data_o_2;
    logic                                 input_valid_o;

    modport master (
        output fmap_length_i, fmap_width_i,
        output input_addr_x_i_1, input_addr_y_i_1,
        output input_addr_x_i_2, input_addr_y_i_2,
        output input_request_i,
        input  input_data_o_1, input_data_o_2, input_valid_o
    );

    modport slave (
        input  fmap_length_i, fmap_width_i,
        input  input_addr_x_i_1, input_addr_y_i_1,
        input  input_addr_x_i_2, input_addr_y_i_2,
        input  input_request_i,
        output input_data_o_1, input_data_o_2, input_valid_o
    );
endinterface

// File: rtl/input_tile_fetcher.sv
// Input tile fetcher: on a request, latches two tile origins and the map
// extent, reads 2x6 rows of 6 pixels from the feature-map SRAM through one
// read port, zero-pads pixels outside the map, and pulses valid once both
// 6x6 tiles are complete (cycle 14 after the request is sampled).
//
// Ports:
//   clk          clock, rising edge
//   reset        synchronous, active-low reset
//   ctrl         tile request bus (slave side)
//   mem_ren_o    SRAM read enable
//   mem_row_o    SRAM row index
//   mem_col_o    SRAM start column
//   mem_rdata_i  6 pixels of the addressed row, column offset c in slice c;
//                returned one cycle after mem_ren_o
module input_tile_fetcher #(
    parameter int DATA_W = 16,
    parameter int TILE   = 6
) (
    input  logic                   clk,
    input  logic                   reset,
    input_tile_fetcher_if.slave    ctrl,
    output logic                   mem_ren_o,
    output logic [15:0]            mem_row_o,
    output logic [15:0]            mem_col_o,
    input  logic [TILE*DATA_W-1:0] mem_rdata_i
);
    localparam logic [3:0] LAST_READ = 4'(2 * TILE - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_DRAIN,
        S_VALID,
        S_HOLD
    } state_t;

    state_t      state_q;
    logic [15:0] x1_q, y1_q, x2_q, y2_q, len_q, wid_q;
    logic [3:0]  n_q;

    // Registered SRAM request and the row slot it belongs to. A slot exists
    // for every row, even when no read is issued, so padding rows follow
    // the same timing as real rows.
    logic        mem_ren_q;
    logic [15:0] mem_row_q, mem_col_q;
    logic        slot_q, slot_tile_q;
    logic [2:0]  slot_row_q;

    // Tag of the slot whose data arrives in the current cycle.
    logic        tag_vld_q, tag_tile_q, tag_ren_q;
    logic [2:0]  tag_row_q;

    logic        valid_q;
    logic [TILE-1:0][TILE-1:0][DATA_W-1:0] tile1_q, tile2_q;

    // ------------------------------------------------------------------
    // Next read plan. In IDLE it describes read 0 straight from the bus
    // inputs (the latch happens on the same edge); in ISSUE it describes
    // read n+1 from the latched values.
    // ------------------------------------------------------------------
    logic [3:0]  plan_n;
    logic        plan_tile;
    logic [2:0]  plan_r;
    logic [15:0] plan_x, plan_y, plan_len, plan_wid;
    logic [16:0] plan_sum;
    logic        plan_ren;

    always_comb begin
        plan_n    = (state_q == S_IDLE) ? 4'd0 : n_q + 4'd1;
        plan_tile = (plan_n >= 4'(TILE));
        plan_r    = plan_tile ? 3'(plan_n - 4'(TILE)) : plan_n[2:0];
        if (state_q == S_IDLE) begin
            plan_x   = ctrl.input_addr_x_i_1;
            plan_y   = ctrl.input_addr_y_i_1;
            plan_len = ctrl.fmap_length_i;
            plan_wid = ctrl.fmap_width_i;
        end else begin
            plan_x   = plan_tile ? x2_q : x1_q;
            plan_y   = plan_tile ? y2_q : y1_q;
            plan_len = len_q;
            plan_wid = wid_q;
        end
        // 17-bit sum: an origin near 0xFFFF must not wrap back into range.
        plan_sum = {1'b0, plan_y} + 17'(plan_r);
        plan_ren = (plan_sum < {1'b0, plan_len}) && (plan_wid != 16'd0);
    end

    // ------------------------------------------------------------------
    // Control FSM with registered outputs
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= S_IDLE;
            x1_q        <= '0;
            y1_q        <= '0;
            x2_q        <= '0;
            y2_q        <= '0;
            len_q       <= '0;
            wid_q       <= '0;
            n_q         <= '0;
            mem_ren_q   <= 1'b0;
            mem_row_q   <= '0;
            mem_col_q   <= '0;
            slot_q      <= 1'b0;
            slot_tile_q <= 1'b0;
            slot_row_q  <= '0;
            tag_vld_q   <= 1'b0;
            tag_tile_q  <= 1'b0;
            tag_row_q   <= '0;
            tag_ren_q   <= 1'b0;
            valid_q     <= 1'b0;
        end else begin
            tag_vld_q  <= slot_q;
            tag_tile_q <= slot_tile_q;
            tag_row_q  <= slot_row_q;
            tag_ren_q  <= mem_ren_q;
            valid_q    <= 1'b0;

            case (state_q)
                S_IDLE: begin
                    if (ctrl.input_request_i) begin
                        x1_q        <= ctrl.input_addr_x_i_1;
                        y1_q        <= ctrl.input_addr_y_i_1;
                        x2_q        <= ctrl.input_addr_x_i_2;
                        y2_q        <= ctrl.input_addr_y_i_2;
                        len_q       <= ctrl.fmap_length_i;
                        wid_q       <= ctrl.fmap_width_i;
                        n_q         <= 4'd0;
                        slot_q      <= 1'b1;
                        slot_tile_q <= plan_tile;
                        slot_row_q  <= plan_r;
                        mem_ren_q   <= plan_ren;
                        mem_row_q   <= plan_sum[15:0];
                        mem_col_q   <= plan_x;
                        state_q     <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    if (n_q == LAST_READ) begin
                        slot_q    <= 1'b0;
                        mem_ren_q <= 1'b0;
                        state_q   <= S_DRAIN;
                    end else begin
                        n_q         <= n_q + 4'd1;
                        slot_tile_q <= plan_tile;
                        slot_row_q  <= plan_r;
                        mem_ren_q   <= plan_ren;
                        mem_row_q   <= plan_sum[15:0];
                        mem_col_q   <= plan_x;
                    end
                end
                S_DRAIN: begin
                    valid_q <= 1'b1;
                    state_q <= S_VALID;
                end
                S_VALID: begin
                    state_q <= S_HOLD;
                end
                S_HOLD: begin
                    // Request must drop before another fetch may start.
                    if (!ctrl.input_request_i) begin
                        state_q <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Row capture with column padding
    // ------------------------------------------------------------------
    logic [15:0]                   tag_x;
    logic [TILE-1:0][DATA_W-1:0]   row_pix;

    assign tag_x = tag_tile_q ? x2_q : x1_q;

    genvar gi;
    generate
        for (gi = 0; gi < TILE; gi++) begin : g_col
            logic [16:0] col_sum;
            assign col_sum     = {1'b0, tag_x} + 17'(gi);
            // Rows with no read carry no SRAM data, so they are zero too.
            assign row_pix[gi] = (tag_ren_q && (col_sum < {1'b0, wid_q}))
                               ? mem_rdata_i[DATA_W*gi +: DATA_W] : '0;
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (!reset) begin
            tile1_q <= '0;
            tile2_q <= '0;
        end else if (tag_vld_q) begin
            if (tag_tile_q) begin
                tile2_q[tag_row_q] <= row_pix;
            end else begin
                tile1_q[tag_row_q] <= row_pix;
            end
        end
    end

    assign mem_ren_o           = mem_ren_q;
    assign mem_row_o           = mem_row_q;
    assign mem_col_o           = mem_col_q;
    assign ctrl.input_valid_o  = valid_q;
    assign ctrl.input_data_o_1 = tile1_q;
    assign ctrl.input_data_o_2 = tile2_q;

endmodule

// File: tb/tb_input_tile_fetcher.sv
// Self-checking bench for input_tile_fetcher. A small model pushes the
// expected read sequence and tiles into scoreboard queues when a fetch is
// set up; each test task runs the fetch, then pops and compares.
module tb_input_tile_fetcher;

    typedef logic [5:0][5:0][15:0] tile_t;
    typedef struct {
        tile_t t1;
        tile_t t2;
    } exp_tiles_t;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        mem_ren;
    logic [15:0] mem_row, mem_col;
    logic [95:0] mem_rdata = '0;

    int checks = 0;
    int errors = 0;

    logic [31:0] exp_reads[$];
    exp_tiles_t  exp_tiles[$];
    logic [31:0] obs_reads[$];
    int          obs_valid[$];
    tile_t       obs_t1, obs_t2, obs_end_t1, obs_end_t2, obs_rst_t1, obs_rst_t2;
    logic        obs_rst_ren;

    input_tile_fetcher_if #(.DATA_W(16)) bus();

    input_tile_fetcher #(.DATA_W(16), .TILE(6)) dut (
        .clk         (clk),
        .reset       (reset),
        .ctrl        (bus),
        .mem_ren_o   (mem_ren),
        .mem_row_o   (mem_row),
        .mem_col_o   (mem_col),
        .mem_rdata_i (mem_rdata)
    );

    always #5 clk = ~clk;

    // SRAM model: F[r][c] = r*64 + c; garbage when not enabled.
    always @(posedge clk) begin
        for (int c = 0; c < 6; c++) begin
            mem_rdata[c*16 +: 16] <= mem_ren
                ? 16'(int'(mem_row) * 64 + int'(mem_col) + c) : 16'hBEEF;
        end
    end

    function automatic logic [15:0] model_pix(int len, int wid, int x, int y, int r, int c);
        int yy = y + r;
        int xx = x + c;
        if (yy >= len || xx >= wid) return 16'd0;
        return 16'(yy * 64 + xx);
    endfunction

    task automatic set_inputs(int x1, int y1, int x2, int y2, int len, int wid);
        bus.input_addr_x_i_1 = 16'(x1);
        bus.input_addr_y_i_1 = 16'(y1);
        bus.input_addr_x_i_2 = 16'(x2);
        bus.input_addr_y_i_2 = 16'(y2);
        bus.fmap_length_i    = 16'(len);
        bus.fmap_width_i     = 16'(wid);
    endtask

    task automatic push_expected(int x1, int y1, int x2, int y2, int len, int wid);
        exp_tiles_t e;
        for (int n = 0; n < 12; n++) begin
            int r = n % 6;
            int x = (n < 6) ? x1 : x2;
            int y = (n < 6) ? y1 : y2;
            if (y + r < len && wid != 0) exp_reads.push_back({16'(y + r), 16'(x)});
        end
        for (int r = 0; r < 6; r++) begin
            for (int c = 0; c < 6; c++) begin
                e.t1[r][c] = model_pix(len, wid, x1, y1, r, c);
                e.t2[r][c] = model_pix(len, wid, x2, y2, r, c);
            end
        end
        exp_tiles.push_back(e);
    endtask

    // Raises request in cycle 0 and observes cycles 1..30. Request drops
    // 'hold' cycles after the first valid; rst_at/frz_at >0 inject a reset
    // or an origin change in that cycle.
    task automatic run_fetch(input int hold, input int rst_at, input int frz_at);
        int vfirst = -1;
        obs_reads.delete();
        obs_valid.delete();
        obs_t1 = '1;
        obs_t2 = '1;
        @(negedge clk);
        bus.input_request_i = 1'b1;
        @(posedge clk);
        #1;
        for (int k = 1; k <= 30; k++) begin
            if (mem_ren) obs_reads.push_back({mem_row, mem_col});
            if (bus.input_valid_o) begin
                obs_valid.push_back(k);
                if (vfirst < 0) begin
                    vfirst = k;
                    obs_t1 = bus.input_data_o_1;
                    obs_t2 = bus.input_data_o_2;
                end
            end
            if (rst_at > 0 && k == rst_at + 1) begin
                obs_rst_ren = mem_ren;
                obs_rst_t1  = bus.input_data_o_1;
                obs_rst_t2  = bus.input_data_o_2;
                reset = 1'b1;
            end
            if (k == frz_at) bus.input_addr_y_i_1 = 16'd40;
            if (k == rst_at) begin
                reset = 1'b0;
                bus.input_request_i = 1'b0;
            end
            if (vfirst > 0 && k == vfirst + hold) bus.input_request_i = 1'b0;
            @(posedge clk);
            #1;
        end
        obs_end_t1 = bus.input_data_o_1;
        obs_end_t2 = bus.input_data_o_2;
        $display("fetch: reads=%0d valids=%0d first_valid=%0d", obs_reads.size(),
                 obs_valid.size(), vfirst);
    endtask

    task automatic test_reset();
        reset = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (mem_ren !== 1'b0 || mem_row !== 16'd0 || mem_col !== 16'd0) begin
            errors++;
            $display("FAIL reset mem got ren=%0d row=%0d col=%0d want 0 0 0", mem_ren, mem_row, mem_col);
        end
        checks++;
        if (bus.input_valid_o !== 1'b0) begin
            errors++;
            $display("FAIL reset valid got %0d want 0", bus.input_valid_o);
        end
        checks++;
        if (bus.input_data_o_1 !== '0 || bus.input_data_o_2 !== '0) begin
            errors++;
            $display("FAIL reset tiles got nonzero want 0");
        end
        @(negedge clk);
        reset = 1'b1;
        repeat (2) @(posedge clk);
    endtask

    task automatic test_basic();
        exp_tiles_t et;
        logic [31:0] er;
        set_inputs(0, 0, 0, 6, 12, 12);
        push_expected(0, 0, 0, 6, 12, 12);
        run_fetch(1, -1, -1);
        checks++;
        if (obs_reads.size() != exp_reads.size()) begin
            errors++;
            $display("FAIL basic read_count got %0d want %0d", obs_reads.size(), exp_reads.size());
        end
        while (exp_reads.size() > 0) begin
            er = exp_reads.pop_front();
            checks++;
            if (obs_reads.size() == 0) begin
                errors++;
                $display("FAIL basic read missing want row %0d col %0d", er[31:16], er[15:0]);
            end else if (obs_reads[0] !== er) begin
                errors++;
                $display("FAIL basic read got row %0d col %0d want row %0d col %0d",
                         obs_reads[0][31:16], obs_reads[0][15:0], er[31:16], er[15:0]);
            end
            if (obs_reads.size() > 0) void'(obs_reads.pop_front());
        end
        checks++;
        if (obs_valid.size() != 1 || obs_valid[0] != 14) begin
            errors++;
            $display("FAIL basic valid got count %0d first %0d want count 1 cycle 14",
                     obs_valid.size(), obs_valid[0]);
        end
        et = exp_tiles.pop_front();
        for (int r = 0; r < 6; r++) begin
            for (int c = 0; c < 6; c++) begin
                checks++;
                if (obs_t1[r][c] !== et.t1[r][c] || obs_t2[r][c] !== et.t2[r][c]) begin
                    errors++;
                    $display("FAIL basic tile[%0d][%0d] got %0d/%0d want %0d/%0d", r, c,
                             obs_t1[r][c], obs_t2[r][c], et.t1[r][c], et.t2[r][c]);
                end
            end
        end
        checks++;
        if (obs_t2[2][3] !== 16'd515) begin
            errors++;
            $display("FAIL basic tile2_2_3 got %0d want 515", obs_t2[2][3]);
        end
    endtask

    task automatic test_row_padding();
        exp_tiles_t et;
        logic [31:0] er;
        set_inputs(0, 0, 0, 6, 8, 12);
        push_expected(0, 0, 0, 6, 8, 12);
        run_fetch(1, -1, -1);
        checks++;
        if (obs_reads.size() != 8 || exp_reads.size() != 8) begin
            errors++;
            $display("FAIL rowpad read_count got %0d want 8", obs_reads.size());
        end
        while (exp_reads.size() > 0) begin
            er = exp_reads.pop_front();
            checks++;
            if (obs_reads.size() == 0 || obs_reads[0] !== er) begin
                errors++;
                $display("FAIL rowpad read got %0h want %0h", obs_reads.size() ? obs_reads[0] : 32'hFFFFFFFF, er);
            end
            if (obs_reads.size() > 0) void'(obs_reads.pop_front());
        end
        checks++;
        if (obs_valid.size() != 1 || obs_valid[0] != 14) begin
            errors++;
            $display("FAIL rowpad valid got count %0d first %0d want count 1 cycle 14",
                     obs_valid.size(), obs_valid[0]);
        end
        et = exp_tiles.pop_front();
        for (int r = 0; r < 6; r++) begin
            for (int c = 0; c < 6; c++) begin
                checks++;
                if (obs_t1[r][c] !== et.t1[r][c] || obs_t2[r][c] !== et.t2[r][c]) begin
                    errors++;
                    $display("FAIL rowpad tile[%0d][%0d] got %0d/%0d want %0d/%0d", r, c,
                             obs_t1[r][c], obs_t2[r][c], et.t1[r][c], et.t2[r][c]);
                end
            end
        end
        checks++;
        if (obs_t2[1][0] !== 16'd448 || obs_t2[5][5] !== 16'd0) begin
            errors++;
            $display("FAIL rowpad tile2 got [1][0]=%0d [5][5]=%0d want 448 0", obs_t2[1][0], obs_t2[5][5]);
        end
    endtask

    task automatic test_col_padding();
        exp_tiles_t et;
        logic [31:0] er;
        set_inputs(0, 0, 0, 6, 12, 4);
        push_expected(0, 0, 0, 6, 12, 4);
        run_fetch(1, -1, -1);
        checks++;
        if (obs_reads.size() != exp_reads.size()) begin
            errors++;
            $display("FAIL colpad read_count got %0d want %0d", obs_reads.size(), exp_reads.size());
        end
        while (exp_reads.size() > 0) begin
            er = exp_reads.pop_front();
            checks++;
            if (obs_reads.size() == 0 || obs_reads[0] !== er) begin
                errors++;
                $display("FAIL colpad read got %0h want %0h", obs_reads.size() ? obs_reads[0] : 32'hFFFFFFFF, er);
            end
            if (obs_reads.size() > 0) void'(obs_reads.pop_front());
        end
        et = exp_tiles.pop_front();
        for (int r = 0; r < 6; r++) begin
            for (int c = 0; c < 6; c++) begin
                checks++;
                if (obs_t1[r][c] !== et.t1[r][c] || obs_t2[r][c] !== et.t2[r][c]) begin
                    errors++;
                    $display("FAIL colpad tile[%0d][%0d] got %0d/%0d want %0d/%0d", r, c,
                             obs_t1[r][c], obs_t2[r][c], et.t1[r][c], et.t2[r][c]);
                end
            end
        end
        checks++;
        if (obs_t1[1][3] !== 16'd67 || obs_t1[1][4] !== 16'd0 || obs_t1[3][5] !== 16'd0) begin
            errors++;
            $display("FAIL colpad tile1 got [1][3]=%0d [1][4]=%0d [3][5]=%0d want 67 0 0",
                     obs_t1[1][3], obs_t1[1][4], obs_t1[3][5]);
        end
    endtask

    task automatic test_handshake();
        exp_tiles_t et;
        set_inputs(2, 1, 3, 4, 12, 12);
        // Two requests, two expected fetches on the scoreboard.
        push_expected(2, 1, 3, 4, 12, 12);
        push_expected(2, 1, 3, 4, 12, 12);
        for (int pass = 0; pass < 2; pass++) begin
            run_fetch(3, -1, -1);
            checks++;
            if (obs_valid.size() != 1 || obs_valid[0] != 14) begin
                errors++;
                $display("FAIL handshake pass%0d valid got count %0d first %0d want count 1 cycle 14",
                         pass, obs_valid.size(), obs_valid[0]);
            end
            checks++;
            if (obs_reads.size() != 12) begin
                errors++;
                $display("FAIL handshake pass%0d read_count got %0d want 12", pass, obs_reads.size());
            end
            for (int i = 0; i < 12; i++) begin
                logic [31:0] er = exp_reads.pop_front();
                checks++;
                if (i >= obs_reads.size() || obs_reads[i] !== er) begin
                    errors++;
                    $display("FAIL handshake pass%0d read%0d got %0h want %0h", pass, i,
                             (i < obs_reads.size()) ? obs_reads[i] : 32'hFFFFFFFF, er);
                end
            end
            et = exp_tiles.pop_front();
            checks++;
            if (obs_t1 !== et.t1 || obs_t2 !== et.t2) begin
                errors++;
                $display("FAIL handshake pass%0d tiles got t1[0][0]=%0d t2[0][0]=%0d want %0d %0d",
                         pass, obs_t1[0][0], obs_t2[0][0], et.t1[0][0], et.t2[0][0]);
            end
        end
    endtask

    task automatic test_reset_mid_fetch();
        exp_tiles_t et;
        set_inputs(1, 1, 1, 5, 12, 12);
        run_fetch(1, 5, -1);
        checks++;
        if (obs_rst_ren !== 1'b0) begin
            errors++;
            $display("FAIL midreset ren got %0d want 0", obs_rst_ren);
        end
        checks++;
        if (obs_rst_t1 !== '0 || obs_rst_t2 !== '0) begin
            errors++;
            $display("FAIL midreset tiles after reset got t1[0][0]=%0d want 0", obs_rst_t1[0][0]);
        end
        checks++;
        if (obs_valid.size() != 0) begin
            errors++;
            $display("FAIL midreset valid got count %0d want 0", obs_valid.size());
        end
        checks++;
        if (obs_reads.size() != 5) begin
            errors++;
            $display("FAIL midreset read_count got %0d want 5", obs_reads.size());
        end
        checks++;
        if (obs_end_t1 !== '0 || obs_end_t2 !== '0) begin
            errors++;
            $display("FAIL midreset late_data got t1[0][0]=%0d t1[4][0]=%0d want 0 0",
                     obs_end_t1[0][0], obs_end_t1[4][0]);
        end
        // Fresh request after the reset.
        push_expected(1, 1, 1, 5, 12, 12);
        run_fetch(1, -1, -1);
        checks++;
        if (obs_valid.size() != 1 || obs_valid[0] != 14) begin
            errors++;
            $display("FAIL midreset refetch valid got count %0d first %0d want count 1 cycle 14",
                     obs_valid.size(), obs_valid[0]);
        end
        checks++;
        if (obs_reads.size() != exp_reads.size()) begin
            errors++;
            $display("FAIL midreset refetch read_count got %0d want %0d", obs_reads.size(), exp_reads.size());
        end
        exp_reads.delete();
        et = exp_tiles.pop_front();
        checks++;
        if (obs_t1 !== et.t1 || obs_t2 !== et.t2) begin
            errors++;
            $display("FAIL midreset refetch tiles got t1[5][5]=%0d t2[5][5]=%0d want %0d %0d",
                     obs_t1[5][5], obs_t2[5][5], et.t1[5][5], et.t2[5][5]);
        end
    endtask

    task automatic test_input_freeze();
        exp_tiles_t et;
        set_inputs(0, 0, 0, 6, 12, 12);
        push_expected(0, 0, 0, 6, 12, 12);
        run_fetch(1, -1, 3);
        bus.input_addr_y_i_1 = 16'd0;
        checks++;
        if (obs_reads.size() != exp_reads.size()) begin
            errors++;
            $display("FAIL freeze read_count got %0d want %0d", obs_reads.size(), exp_reads.size());
        end
        for (int i = 0; exp_reads.size() > 0; i++) begin
            logic [31:0] er = exp_reads.pop_front();
            checks++;
            if (i >= obs_reads.size() || obs_reads[i] !== er) begin
                errors++;
                $display("FAIL freeze read%0d got %0h want %0h", i,
                         (i < obs_reads.size()) ? obs_reads[i] : 32'hFFFFFFFF, er);
            end
        end
        et = exp_tiles.pop_front();
        checks++;
        if (obs_t1 !== et.t1 || obs_t2 !== et.t2) begin
            errors++;
            $display("FAIL freeze tiles got t1[5][0]=%0d want %0d", obs_t1[5][0], et.t1[5][0]);
        end
    endtask

    task automatic test_degenerate();
        exp_tiles_t et;
        set_inputs(0, 0, 0, 6, 0, 12);
        push_expected(0, 0, 0, 6, 0, 12);
        run_fetch(1, -1, -1);
        checks++;
        if (obs_reads.size() != exp_reads.size()) begin
            errors++;
            $display("FAIL degenerate read_count got %0d want %0d", obs_reads.size(), exp_reads.size());
        end
        exp_reads.delete();
        checks++;
        if (obs_valid.size() != 1 || obs_valid[0] != 14) begin
            errors++;
            $display("FAIL degenerate valid got count %0d first %0d want count 1 cycle 14",
                     obs_valid.size(), obs_valid[0]);
        end
        et = exp_tiles.pop_front();
        checks++;
        if (obs_t1 !== et.t1 || obs_t2 !== et.t2) begin
            errors++;
            $display("FAIL degenerate tiles got t1[0][0]=%0d t2[0][0]=%0d want 0 0", obs_t1[0][0], obs_t2[0][0]);
        end
    endtask

    initial begin
        bus.input_request_i = 1'b0;
        set_inputs(0, 0, 0, 6, 12, 12);
        test_reset();
        test_basic();
        test_row_padding();
        test_col_padding();
        test_handshake();
        test_reset_mid_fetch();
        test_input_freeze();
        test_degenerate();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/input_tile_fetcher.md
Name: input_tile_fetcher

Overview:
- Sits directly upstream of the input-transform data controller and services its tile request handshake.
- On a request, latches two tile origins, then reads 12 six-pixel rows from the on-chip feature-map SRAM (6 rows per tile) through one read port.
- Zero-pads every pixel outside the feature map, presents two signed 6x6 tiles, and pulses valid once per request.

Parameters:
- DATA_W, 16, pixel width in bits (two's complement).
- TILE, 6, tile edge in pixels. Fixed at 6 for this revision; other values are unsupported.

Ports:
- clk  in  1  clock; all logic on rising edge.
- reset  in  1  synchronous, active-low reset.
- fmap_length_i  in  16  feature-map row count (y extent).
- fmap_width_i  in  16  feature-map column count (x extent).
- input_addr_x_i_1  in  16  tile 1 origin column.
- input_addr_y_i_1  in  16  tile 1 origin row.
- input_addr_x_i_2  in  16  tile 2 origin column.
- input_addr_y_i_2  in  16  tile 2 origin row.
- input_request_i  in  1  fetch request level from the controller.
- input_data_o_1  out  signed DATA_W x [5:0][5:0]  tile 1.
- input_data_o_2  out  signed DATA_W x [5:0][5:0]  tile 2.
- input_valid_o  out  1  one-cycle pulse: both tiles are complete.
- mem_ren_o  out  1  SRAM read enable.
- mem_row_o  out  16  SRAM row index.
- mem_col_o  out  16  SRAM start column.
- mem_rdata_i  in  6*DATA_W  pixels at columns col..col+5 of the addressed row. Bits [DATA_W*(c+1)-1:DATA_W*c] hold column offset c. Data is returned 1 cycle after mem_ren_o.

Behaviour:
- Tile mapping: data_o_t[r][c] = F[y_t + r][x_t + c], for r and c in 0..5.
- Reset (reset==0 at a clock edge):
  - State goes to IDLE and all counters clear.
  - mem_ren_o, input_valid_o, mem_row_o and mem_col_o go to 0.
  - Both output tiles are cleared to 0.
  - Reset mid-fetch aborts the fetch: no valid pulse, mem_ren_o is 0 from the next cycle, and late SRAM data is ignored.
- FSM states: IDLE, ISSUE, DRAIN, VALID, HOLD.
- IDLE:
  - If input_request_i==1, latch all four origin coordinates plus fmap_length_i and fmap_width_i, clear the read counter n, and go to ISSUE.
  - Latched values are frozen until the next IDLE; input changes mid-fetch are ignored.
- ISSUE (12 cycles, n = 0..11):
  - n<6 reads tile 1 row r=n; n>=6 reads tile 2 row r=n-6.
  - mem_row_o = y_t + r and mem_col_o = x_t, computed as 16-bit sums.
  - mem_ren_o = 1 only if y_t + r < length. Evaluate the sum at 17 bits so it cannot wrap; an overflowing sum counts as out of range.
  - Out-of-range rows issue no read, and that row is written as zeros.
  - After n==11, go to DRAIN.
- Capture:
  - A read issued in cycle k is written into its tile row at the end of cycle k+1.
  - Element c is forced to 0 when x_t + c >= width (17-bit compare).
  - A row/tile pipeline tag travels with each read; padding rows use the same tag path so row timing is uniform.
- DRAIN: 1 cycle, captures the last read, then go to VALID.
- VALID:
  - input_valid_o = 1 for exactly this cycle; both tiles are fully updated in this cycle.
  - Then go to HOLD.
- HOLD:
  - Wait while input_request_i==1; the controller keeps request high for several cycles after valid.
  - No reads and no second valid occur in HOLD.
  - On request==0, go to IDLE.
- Latency: request is sampled in IDLE at cycle 0, reads occur in cycles 1..12, DRAIN is cycle 13, and input_valid_o is high in cycle 14.
- Output tiles hold their value after VALID until rows are overwritten by the next fetch. The controller samples only on valid.
- Simultaneous events: reset has priority over everything. A request arriving in VALID is not accepted until it has dropped in HOLD and been re-seen in IDLE.
- Degenerate map: length==0 or width==0 issues no reads and still produces a valid pulse in cycle 14 with all-zero tiles.
- Pixels are passed through unmodified; no arithmetic is applied to data.

Test Plan:
- Basic fetch: SRAM model F[r][c] = r*64+c, length=12, width=12, origins (x1,y1)=(0,0), (x2,y2)=(0,6), request held.
  -> 12 reads with rows 0..11; valid high only in cycle 14; tile1[r][c] = r*64+c; tile2[2][3] = 515.
- Row padding: length=8, (x2,y2)=(0,6).
  -> mem_ren_o low for tile 2 rows 2..5 (8 reads total); tile2 rows 2..5 all 0; tile2[1][0] = 448.
- Column padding: width=4, x1=0.
  -> every row of tile1 has columns 4 and 5 equal to 0; tile1[1][3] = 67.
- Handshake: request stays high 3 cycles past valid, then low, then high again.
  -> exactly one valid pulse per request; a second fetch starts only after the re-assertion, with its valid in cycle 14 counted from the re-assertion.
- Reset mid-fetch: reset=0 in cycle 5 of a fetch.
  -> next cycle mem_ren_o=0 and tiles are 0; no valid pulse; a fresh request after reset completes normally in 14 cycles.
- Input freeze: change input_addr_y_i_1 from 0 to 40 in cycle 3.
  -> the read sequence and tile contents match the values latched at cycle 0.
